fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction fetch stage sitting directly upstream of the decode/execute core: it owns the fetch program counter, drives the synchronous instruction PROM address, and buffers returned instruction words in a small FIFO. It presents one instruction plus its address to the core over a valid/ready handshake. It also accepts a redirect (branch/jump target) that flushes all buffered and in-flight fetches.

## Interface
- DEPTH, 4, queue entries (power of two, ≥2)
- ADDR_W, 16, instruction address width (word addressed)
- INST_W, 32, instruction word width
- RESET_PC, 16'h0000, fetch address after reset
- clk  input  1  clock, all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- prom_addr  output  ADDR_W  PROM address; equals fetch_pc register at all times
- prom_instruction  input  INST_W  PROM data, valid the cycle after the edge that sampled prom_addr
- redirect  input  1  flush and restart fetch at redirect_pc
- redirect_pc  input  ADDR_W  new fetch address
- inst_valid  output  1  head entry present
- inst_ready  input  1  core accepts head this edge
- inst  output  INST_W  head instruction; 0 when empty
- inst_pc  output  ADDR_W  address of head instruction; 0 when empty

## Operation
- State: fetch_pc, pend flag plus pend_pc (one fetch in flight), FIFO of {inst, pc} with rd/wr pointers and count (0..DEPTH).
- Issue: combinational issue = !redirect && (count + pend) < DEPTH. On an issue edge: pend<=1, pend_pc<=fetch_pc, fetch_pc<=fetch_pc+1 (mod 2^ADDR_W, FFFF->0000). No issue: pend<=0, fetch_pc held.
- Credit check uses pre-edge count; a same-edge pop does not create credit.
- Push: at an edge with pend=1 and no redirect, write {prom_instruction, pend_pc} at wr pointer.
- Pop: at an edge with inst_valid && inst_ready, advance rd pointer.
- Push and pop on the same edge: count unchanged. Push never occurs when full (guaranteed by credit rule; assert in bench).
- Redirect (priority over everything): at that edge count<=0, pointers<=0, pend<=0, fetch_pc<=redirect_pc. The word returning for the old in-flight fetch is discarded. A handshake on the redirect edge is still a completed transfer for the core; the queue is cleared regardless.
- inst_valid = (count != 0). inst/inst_pc driven to 0 when count==0.
- Reset (async, any time, including mid-fetch/mid-redirect): fetch_pc=RESET_PC, pend=0, count=0, pointers=0; outputs immediately inst_valid=0, inst=0, inst_pc=0, prom_addr=RESET_PC.

## Timing
- Fetch latency: address issued at edge E0; word written at E1; inst_valid high after E1. First instruction after reset release appears after the 2nd rising edge.
- Redirect latency: redirect at edge R; redirect_pc issued at R+1; its instruction is valid after R+2. inst_valid is low for the cycles after R and R+1.
- Steady-state throughput with inst_ready held high: one instruction per cycle, no bubbles.
- After backpressure release from full: head pops immediately; refill starts at the next edge; the sequence stays contiguous.
- Outputs depend only on registers; there is no combinational path from inst_ready or redirect to any output.

## Test plan
- Reset release, inst_ready=1, PROM mem[i]=32'hA000_0000+i -> inst_valid rises after the 2nd edge; inst/inst_pc = A0000000/0000, A0000001/0001, … one per cycle, no gaps.
- inst_ready=0 from reset -> count reaches 4 holding pcs 0..3; prom_addr settles at 4; no further pushes. Then ready=1 -> delivered pcs 0,1,2,3,4,5,… with no duplicate or skip.
- Streaming, redirect=1 for one cycle with redirect_pc=16'h0100 -> inst_valid low for 2 cycles, then pc 0100 with A0000100, then 0101. No stale pre-redirect instruction is delivered.
- Redirect to 16'hFFFE, ready=1 -> delivered pcs FFFE, FFFF, 0000, 0001 with matching words.
- Full queue, ready=0, redirect=1 with redirect_pc=16'h0020 -> next valid instruction is pc 0020; the old contents are gone.
- reset_n pulsed low asynchronously between edges mid-stream -> inst_valid, inst, inst_pc drop to 0 and prom_addr returns to 0000 without a clock edge. Restart then matches the first scenario.

Source files
------------

// File: rtl/fetch_queue.sv
// Fetch stage: owns the fetch PC, drives the PROM address and buffers
// returned words in a small FIFO presented over valid/ready.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int ADDR_W = 16,
  parameter int INST_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic [ADDR_W-1:0] prom_addr,
  input  logic [INST_W-1:0] prom_instruction,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] pend_pc;
  logic              pend;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;

  logic [INST_W-1:0] mem_inst [DEPTH];
  logic [ADDR_W-1:0] mem_pc   [DEPTH];

  logic [CNT_W:0] used;
  logic           issue;
  logic           push;
  logic           pop;

  // Credit counts the in-flight word; a same-edge pop earns nothing.
  assign used  = {1'b0, count} + {{CNT_W{1'b0}}, pend};
  assign issue = !redirect && (used < DEPTH_C);
  assign push  = pend && !redirect;
  assign pop   = inst_valid && inst_ready;

  assign prom_addr  = fetch_pc;
  assign inst_valid = (count != '0);
  assign inst       = inst_valid ? mem_inst[rd_ptr] : '0;
  assign inst_pc    = inst_valid ? mem_pc[rd_ptr] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc <= RESET_PC;
      pend     <= 1'b0;
      pend_pc  <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc;
      pend     <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      pend <= issue;
      if (issue) begin
        pend_pc  <= fetch_pc;
        fetch_pc <= fetch_pc + ADDR_W'(1);
      end
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_inst[wr_ptr] <= prom_instruction;
      mem_pc[wr_ptr]   <= pend_pc;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: vector table for streaming/redirect/wrap,
// hand sequences for backpressure, async reset and full-queue redirect.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] prom_addr;
  logic [31:0] prom_instruction;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [15:0] inst_pc;

  int n_checks = 0;
  int n_fail = 0;

  fetch_queue dut (
    .clk(clk),
    .reset_n(reset_n),
    .prom_addr(prom_addr),
    .prom_instruction(prom_instruction),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .inst(inst),
    .inst_pc(inst_pc)
  );

  always #5 clk = ~clk;

  // Synchronous PROM model: word = A000_0000 + address.
  always @(posedge clk)
    prom_instruction <= 32'hA000_0000 + {16'h0, prom_addr};

  // A push into a full queue must never happen.
  always @(posedge clk) begin
    if (reset_n === 1'b1) begin
      n_checks++;
      if (dut.pend && !redirect && dut.count == 3'd4) begin
        n_fail++;
        $display("FAIL push_when_full t=%0t count=%0d required<4",
                 $time, dut.count);
      end
    end
  end

  typedef struct {
    logic        ready;
    logic        redir;
    logic [15:0] rpc;
    logic        v;
    logic [15:0] pc;
    logic [15:0] pa;
  } vec_t;

  vec_t vecs[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  task automatic check_outs(string tag, logic v, logic [15:0] pc,
                            logic [15:0] pa);
    logic [31:0] ei;
    logic [15:0] ep;
    ei = v ? 32'hA000_0000 + {16'h0, pc} : 32'h0;
    ep = v ? pc : 16'h0;
    check({tag, ".valid"}, {31'h0, inst_valid}, {31'h0, v});
    check({tag, ".inst"}, inst, ei);
    check({tag, ".inst_pc"}, {16'h0, inst_pc}, {16'h0, ep});
    check({tag, ".prom_addr"}, {16'h0, prom_addr}, {16'h0, pa});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(logic rd, logic rx, logic [15:0] rp, logic v,
                     logic [15:0] pc, logic [15:0] pa);
    vec_t t;
    t.ready = rd; t.redir = rx; t.rpc = rp;
    t.v = v; t.pc = pc; t.pa = pa;
    vecs.push_back(t);
  endtask

  initial begin
    // Streaming from reset, redirect to 0100, redirect to FFFE (wrap).
    add(1, 0, 16'h0000, 0, 16'h0000, 16'h0001);
    add(1, 0, 16'h0000, 1, 16'h0000, 16'h0002);
    add(1, 0, 16'h0000, 1, 16'h0001, 16'h0003);
    add(1, 0, 16'h0000, 1, 16'h0002, 16'h0004);
    add(1, 0, 16'h0000, 1, 16'h0003, 16'h0005);
    add(1, 1, 16'h0100, 0, 16'h0000, 16'h0100);
    add(1, 0, 16'h0000, 0, 16'h0000, 16'h0101);
    add(1, 0, 16'h0000, 1, 16'h0100, 16'h0102);
    add(1, 0, 16'h0000, 1, 16'h0101, 16'h0103);
    add(1, 1, 16'hFFFE, 0, 16'h0000, 16'hFFFE);
    add(1, 0, 16'h0000, 0, 16'h0000, 16'hFFFF);
    add(1, 0, 16'h0000, 1, 16'hFFFE, 16'h0000);
    add(1, 0, 16'h0000, 1, 16'hFFFF, 16'h0001);
    add(1, 0, 16'h0000, 1, 16'h0000, 16'h0002);
    add(1, 0, 16'h0000, 1, 16'h0001, 16'h0003);

    reset_n = 1'b0;
    redirect = 1'b0;
    redirect_pc = 16'h0;
    inst_ready = 1'b1;
    #12;
    check_outs("reset", 0, 16'h0, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    foreach (vecs[i]) begin
      inst_ready = vecs[i].ready;
      redirect = vecs[i].redir;
      redirect_pc = vecs[i].rpc;
      step();
      check_outs($sformatf("vec%0d", i), vecs[i].v, vecs[i].pc, vecs[i].pa);
    end
    redirect = 1'b0;

    // Async reset between edges while streaming.
    #2;
    reset_n = 1'b0;
    #1;
    check_outs("async_rst", 0, 16'h0, 16'h0000);
    inst_ready = 1'b0;
    #2;
    reset_n = 1'b1;

    // Backpressure from reset: fills pcs 0..3, PROM address parks at 4.
    step(); check_outs("bp0", 0, 16'h0, 16'h0001);
    step(); check_outs("bp1", 1, 16'h0, 16'h0002);
    step(); check_outs("bp2", 1, 16'h0, 16'h0003);
    step(); check_outs("bp3", 1, 16'h0, 16'h0004);
    step(); check_outs("bp4", 1, 16'h0, 16'h0004);
    step(); check_outs("bp5", 1, 16'h0, 16'h0004);

    // Release: contiguous delivery, refill one edge later.
    inst_ready = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      check_outs($sformatf("rel%0d", k), 1, 16'(k), 16'(k + 3));
    end

    // Fill again, then redirect while full and stalled.
    inst_ready = 1'b0;
    for (int k = 0; k < 4; k++) step();
    check_outs("full", 1, 16'h0006, 16'h000A);
    redirect = 1'b1;
    redirect_pc = 16'h0020;
    step(); check_outs("fr0", 0, 16'h0, 16'h0020);
    redirect = 1'b0;
    inst_ready = 1'b1;
    step(); check_outs("fr1", 0, 16'h0, 16'h0021);
    step(); check_outs("fr2", 1, 16'h0020, 16'h0022);
    step(); check_outs("fr3", 1, 16'h0021, 16'h0023);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
